// File: rtl/mms_frame_if.sv
// Handshake bundle between a frame producer/consumer and the max/min sequencer.
// Carries frame control, the input beat stream and the result stream.
// master drives requests and beats; slave (the sequencer) drives ready/result.
interface mms_frame_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic             select;
  logic [LEN_W-1:0] frame_len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       result;
  logic             busy;

  modport master (
    output start, select, frame_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  start, select, frame_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mms_frame_ctrl.sv
// Frame max/min sequencer: folds up to 3 buffered beats plus the accumulator through one 4-input compare.
// Latency: N + ceil(N/3) cycles from first accepted beat to out_valid with in_valid held high.
// Backpressure: in_ready only in LOAD; result and out_valid held in DONE until out_ready.
module mms_frame_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  mms_frame_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q;
  logic [LEN_W-1:0] rem_q;
  logic [1:0]       lane_q;
  logic [7:0]       buf_q [0:2];
  logic [7:0]       acc_q;
  logic [7:0]       result_q;
  logic [7:0]       lanes [0:3];
  logic [7:0]       cmp_res;
  logic             in_ready;
  logic             out_valid;
  logic             start_ok;
  logic             beat;

  // Two-input pick shared by both compare stages: sel=0 keeps the larger, sel=1 the smaller.
  function automatic logic [7:0] pick2(input logic [7:0] a, input logic [7:0] b, input logic sel);
    if (sel) pick2 = (a < b) ? a : b;
    else     pick2 = (a > b) ? a : b;
  endfunction

  assign start_ok = bus.start && (bus.frame_len != '0);
  assign beat     = bus.in_valid && in_ready;

  // Build the compare lanes: filled buffers first, unfilled lanes and lane 3 carry the accumulator.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      lanes[i] = (2'(i) < lane_q) ? buf_q[i] : acc_q;
    end
    lanes[3] = acc_q;
    cmp_res  = pick2(pick2(lanes[0], lanes[1], sel_q), pick2(lanes[2], lanes[3], sel_q), sel_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        if (bus.in_valid && (lane_q == 2'd2 || rem_q == LEN_W'(1))) state_d = CMP;
      end
      CMP:  state_d = (rem_q == '0) ? DONE : LOAD;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: latch controls on start, buffer beats, fold them into the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q    <= 1'b0;
      rem_q    <= '0;
      lane_q   <= 2'd0;
      acc_q    <= 8'h00;
      result_q <= 8'h00;
      for (int i = 0; i < 3; i++) buf_q[i] <= 8'h00;
    end else begin
      case (state_q)
        IDLE: if (start_ok) begin
          sel_q  <= bus.select;
          rem_q  <= bus.frame_len;
          lane_q <= 2'd0;
          acc_q  <= bus.select ? 8'hFF : 8'h00;
        end
        LOAD: if (beat) begin
          for (int i = 0; i < 3; i++) begin
            if (lane_q == 2'(i)) buf_q[i] <= bus.in_data;
          end
          lane_q <= lane_q + 2'd1;
          rem_q  <= rem_q - LEN_W'(1);
        end
        CMP: begin
          acc_q  <= cmp_res;
          lane_q <= 2'd0;
          if (rem_q == '0) result_q <= cmp_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mms_frame_ctrl.sv
// Directed plus randomized frames checked against a queue-based max/min reference.
// Checks latency, ready gaps, result hold under backpressure, reset and ignored controls.
// Drives after the rising edge, samples on the falling edge.
module tb_mms_frame_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mms_frame_if #(.LEN_W(8)) bus ();

  mms_frame_ctrl #(.LEN_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  logic [7:0] bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame extreme computed directly over the whole beat list.
  function automatic logic [7:0] ref_mms(input logic sel);
    logic [7:0] r;
    r = bq[0];
    foreach (bq[i]) begin
      if (sel ? (bq[i] < r) : (bq[i] > r)) r = bq[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic sel, input int len);
    bus.start     = 1'b1;
    bus.select    = sel;
    bus.frame_len = len[7:0];
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic sel, input bit gaps,
                           input int odelay, input bit chk_lat, input bit t6);
    int n, idx, t, first_cyc, out_cyc, rdy_low;
    bit hs;
    logic [7:0] exp;
    n = bq.size();
    exp = ref_mms(sel);
    first_cyc = 0;
    out_cyc = 0;
    rdy_low = 0;
    start_frame(sel, n);
    idx = 0;
    t = 0;
    while (idx < n && t < 5000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = bq[idx];
      end
      if (t6 && idx == 1) begin
        bus.start     = 1'b1;
        bus.select    = ~sel;
        bus.frame_len = 8'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (bus.in_valid && !bus.in_ready) rdy_low++;
      if (hs && idx == 0) first_cyc = cyc;
      step();
      if (hs) idx++;
      t++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    check({tag, ".beats"}, idx, n);
    if (!gaps) check({tag, ".rdy_low"}, rdy_low, (n - 1) / 3);
    t = 0;
    while (t < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      check({tag, ".cmp_rdy"}, bus.in_ready, 0);
      step();
      t++;
    end
    out_cyc = cyc;
    check({tag, ".out_valid"}, bus.out_valid, 1);
    if (chk_lat) check({tag, ".latency"}, out_cyc - first_cyc, n + (n + 2) / 3);
    bus.out_ready = 1'b0;
    for (int k = 0; k < odelay; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      check({tag, ".hold_res"}, bus.result, exp);
      check({tag, ".hold_vld"}, bus.out_valid, 1);
      check({tag, ".done_rdy"}, bus.in_ready, 0);
      check({tag, ".done_busy"}, bus.busy, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check({tag, ".result"}, bus.result, exp);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check({tag, ".vld_drop"}, bus.out_valid, 0);
    check({tag, ".idle_busy"}, bus.busy, 0);
    check({tag, ".res_kept"}, bus.result, exp);
    step();
  endtask

  initial begin
    int len;
    logic sel;
    bit gaps;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.select    = 1'b0;
    bus.frame_len = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("rst.in_ready", bus.in_ready, 0);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.result", bus.result, 8'h00);
    reset = 1'b0;
    step();

    bq = {8'd10, 8'd200, 8'd37, 8'd199};
    run_frame("t1", 1'b0, 1'b0, 0, 1'b1, 1'b0);

    bq = {8'd9, 8'd3, 8'd250, 8'd3, 8'd7};
    run_frame("t2", 1'b1, 1'b0, 1, 1'b1, 1'b0);

    bq = {8'h80};
    run_frame("t3.len1", 1'b1, 1'b0, 0, 1'b1, 1'b0);

    start_frame(1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3.len0_busy", bus.busy, 0);
      check("t3.len0_rdy", bus.in_ready, 0);
      step();
    end

    bq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("t3.max0", 1'b0, 1'b0, 0, 1'b1, 1'b0);
    bq = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_frame("t3.minff", 1'b1, 1'b0, 0, 1'b1, 1'b0);

    bq.delete();
    for (int i = 0; i < 11; i++) bq.push_back(8'($urandom));
    run_frame("t4", 1'b0, 1'b1, 5, 1'b0, 1'b0);

    start_frame(1'b0, 5);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd250;
    step();
    bus.in_data  = 8'd251;
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("t5.in_ready", bus.in_ready, 0);
    check("t5.out_valid", bus.out_valid, 0);
    check("t5.busy", bus.busy, 0);
    check("t5.result", bus.result, 8'h00);
    reset = 1'b0;
    step();
    bq = {8'd5, 8'd6, 8'd4};
    run_frame("t5.new", 1'b0, 1'b0, 0, 1'b1, 1'b0);

    bq = {8'd20, 8'd90, 8'd33, 8'd60, 8'd11};
    run_frame("t6", 1'b0, 1'b0, 2, 1'b1, 1'b1);

    for (int f = 0; f < 10; f++) begin
      len  = (f == 9) ? 255 : int'($urandom_range(1, 24));
      sel  = 1'($urandom);
      gaps = 1'($urandom);
      bq.delete();
      for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), sel, gaps, int'($urandom_range(0, 3)), !gaps, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
